// File: rtl/enemy_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_spawner
//  Description : Produces up to three enemy targets for the rocket fire
//                logic. Each slot is spawned at a pseudo-random x on the top
//                row, stepped down one pixel per move tick, and freed on a
//                kill or when it reaches the base line. Counts bases hit and
//                raises game_over once LIVES bases have been reached.
//                Optional build macro ENEMY_SPEEDUP_EN shortens the move
//                period as the kill count grows.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_spawner #(
  parameter int OUT_WIDTH      = 8,
  parameter int SPAWN_INTERVAL = 64,
  parameter int MOVE_DIV       = 16,
  parameter int Y_LIMIT        = 200,
  parameter int X_MARGIN       = 8,
  parameter int LIVES          = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 enemy1_kill,
  input  logic                 enemy2_kill,
  input  logic                 enemy3_kill,
  output logic [OUT_WIDTH-1:0] xenemy1,
  output logic [OUT_WIDTH-1:0] yenemy1,
  output logic [OUT_WIDTH-1:0] xenemy2,
  output logic [OUT_WIDTH-1:0] yenemy2,
  output logic [OUT_WIDTH-1:0] xenemy3,
  output logic [OUT_WIDTH-1:0] yenemy3,
  output logic                 spawn_enemy1,
  output logic                 spawn_enemy2,
  output logic                 spawn_enemy3,
  output logic                 enemy_reached,
  output logic [3:0]           lives_lost,
  output logic                 game_over
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_NSLOT   = 3;
  localparam int c_SPAWN_W = $clog2(SPAWN_INTERVAL);
  localparam int c_MOVE_W  = $clog2(MOVE_DIV);

  localparam logic [c_SPAWN_W-1:0] c_SPAWN_RELOAD = c_SPAWN_W'(SPAWN_INTERVAL - 1);
  localparam logic [c_MOVE_W-1:0]  c_MOVE_RELOAD  = c_MOVE_W'(MOVE_DIV - 1);
  localparam logic [c_SPAWN_W-1:0] c_SPAWN_ONE    = c_SPAWN_W'(1);
  localparam logic [c_MOVE_W-1:0]  c_MOVE_ONE     = c_MOVE_W'(1);

  localparam logic [OUT_WIDTH-1:0] c_X_LO    = OUT_WIDTH'(X_MARGIN);
  localparam logic [OUT_WIDTH-1:0] c_X_HI    = OUT_WIDTH'((2 ** OUT_WIDTH) - 1 - X_MARGIN);
  localparam logic [OUT_WIDTH-1:0] c_Y_LIMIT = OUT_WIDTH'(Y_LIMIT);
  localparam logic [OUT_WIDTH-1:0] c_Y_ONE   = OUT_WIDTH'(1);
  localparam logic [3:0]           c_LIVES   = 4'(LIVES);
  localparam logic [15:0]          c_LFSR_SEED = 16'hACE1;

  // Top-level game states
  localparam logic [1:0] c_ST_RESET = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_PAUSE = 2'd2;
  localparam logic [1:0] c_ST_OVER  = 2'd3;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [15:0]          r_lfsr;
  logic [c_SPAWN_W-1:0] r_spawn_cnt;
  logic [c_MOVE_W-1:0]  r_move_cnt;
  logic [OUT_WIDTH-1:0] r_x [c_NSLOT];
  logic [OUT_WIDTH-1:0] r_y [c_NSLOT];
  logic [c_NSLOT-1:0]   r_active;
  logic                 r_reached;
  logic [3:0]           r_lives;
  logic                 r_over;

  logic                 w_run;
  logic                 w_live;
  logic                 w_spawn_fire;
  logic                 w_tick;
  logic                 w_go_over;
  logic                 w_lfsr_fb;
  logic [c_NSLOT-1:0]   w_kill_req;
  logic [c_NSLOT-1:0]   w_kill_ok;
  logic [c_NSLOT-1:0]   w_reach;
  logic [c_NSLOT-1:0]   w_step;
  logic [c_NSLOT-1:0]   w_spawn_sel;
  logic [1:0]           w_reach_cnt;
  logic [4:0]           w_lives_sum;
  logic [3:0]           w_lives_next;
  logic [OUT_WIDTH-1:0] w_lfsr_x;
  logic [OUT_WIDTH-1:0] w_spawn_x;
  logic [c_MOVE_W-1:0]  w_move_reload;

  assign w_kill_req = {enemy3_kill, enemy2_kill, enemy1_kill};

  // Work (counting, moving, spawning) happens only in cycles spent in RUN;
  // kills are honoured in RUN and PAUSE.
  assign w_run        = (r_state == c_ST_RUN);
  assign w_live       = (r_state == c_ST_RUN) || (r_state == c_ST_PAUSE);
  assign w_spawn_fire = w_run && (r_spawn_cnt == '0);
  assign w_tick       = w_run && (r_move_cnt == '0);

  // Fibonacci LFSR, taps 16/14/13/11 mapped onto bits 15/13/12/10
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_x  = r_lfsr[OUT_WIDTH-1:0];

  // Keep spawned enemies at least X_MARGIN pixels away from either edge
  assign w_spawn_x = (w_lfsr_x < c_X_LO) ? c_X_LO :
                     (w_lfsr_x > c_X_HI) ? c_X_HI : w_lfsr_x;

  // Per-slot kill, reach, step and spawn-target decode
  always_comb begin
    w_kill_ok   = '0;
    w_reach     = '0;
    w_step      = '0;
    w_spawn_sel = '0;
    for (int i = 0; i < c_NSLOT; i++) begin
      w_kill_ok[i] = w_live && w_kill_req[i] && r_active[i];
      // A kill landing on the same cycle as a reach takes precedence
      w_reach[i]   = w_tick && r_active[i] && !w_kill_ok[i] && (r_y[i] == c_Y_LIMIT);
      w_step[i]    = w_tick && r_active[i] && !w_kill_ok[i] && (r_y[i] != c_Y_LIMIT);
    end
    // Descending scan so the lowest-index free slot is the one left selected.
    // A slot being killed or reaching this cycle is still active, hence busy.
    for (int i = c_NSLOT - 1; i >= 0; i--) begin
      if (w_spawn_fire && !r_active[i]) begin
        w_spawn_sel    = '0;
        w_spawn_sel[i] = 1'b1;
      end
    end
  end

  // Number of slots reaching on this tick and the saturated life count
  always_comb begin
    w_reach_cnt  = {1'b0, w_reach[0]} + {1'b0, w_reach[1]} + {1'b0, w_reach[2]};
    w_lives_sum  = {1'b0, r_lives} + {3'b000, w_reach_cnt};
    w_lives_next = (w_lives_sum > {1'b0, c_LIVES}) ? c_LIVES : w_lives_sum[3:0];
    w_go_over    = w_live && (w_lives_next == c_LIVES);
  end

`ifdef ENEMY_SPEEDUP_EN
  logic [7:0]  r_kills;
  logic [1:0]  w_kill_cnt;
  logic [8:0]  w_kills_sum;
  logic [1:0]  w_level;
  logic [31:0] w_div_shifted;

  // Speed level from the kill count and the resulting prescaler reload
  always_comb begin
    w_kill_cnt    = {1'b0, w_kill_ok[0]} + {1'b0, w_kill_ok[1]} + {1'b0, w_kill_ok[2]};
    w_kills_sum   = {1'b0, r_kills} + {7'b0000000, w_kill_cnt};
    w_level       = (r_kills >= 8'd24) ? 2'd3 : r_kills[4:3];
    w_div_shifted = 32'(MOVE_DIV) >> w_level;
    // Never let the period fall below two cycles
    w_move_reload = (w_div_shifted <= 32'd2) ? c_MOVE_ONE
                                             : c_MOVE_W'(w_div_shifted - 32'd1);
  end

  // Honoured-kill counter; holds at its maximum rather than wrapping back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kills <= '0;
    end else if (w_kill_cnt != 2'd0) begin
      r_kills <= w_kills_sum[8] ? 8'hFF : w_kills_sum[7:0];
    end
  end
`else
  assign w_move_reload = c_MOVE_RELOAD;
`endif

  // Game FSM, LFSR and the spawn / move timers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_RESET;
      r_lfsr      <= c_LFSR_SEED;
      r_spawn_cnt <= c_SPAWN_RELOAD;
      r_move_cnt  <= c_MOVE_RELOAD;
    end else begin
      case (r_state)
        c_ST_RESET: begin
          r_state     <= c_ST_RUN;
          r_spawn_cnt <= c_SPAWN_RELOAD;
          r_move_cnt  <= c_MOVE_RELOAD;
        end
        c_ST_RUN: begin
          r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
          r_spawn_cnt <= w_spawn_fire ? c_SPAWN_RELOAD : (r_spawn_cnt - c_SPAWN_ONE);
          r_move_cnt  <= w_tick ? w_move_reload : (r_move_cnt - c_MOVE_ONE);
          if (w_go_over) begin
            r_state <= c_ST_OVER;
          end else if (!enable) begin
            r_state <= c_ST_PAUSE;
          end
        end
        c_ST_PAUSE: begin
          if (w_go_over) begin
            r_state <= c_ST_OVER;
          end else if (enable) begin
            r_state <= c_ST_RUN;
          end
        end
        default: begin
          r_state <= c_ST_OVER;
        end
      endcase
    end
  end

  // Slot occupancy and positions; position holds when a slot is freed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      for (int i = 0; i < c_NSLOT; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_NSLOT; i++) begin
        if (w_spawn_sel[i]) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= w_spawn_x;
          r_y[i]      <= '0;
        end else if (w_kill_ok[i] || w_reach[i]) begin
          r_active[i] <= 1'b0;
        end else if (w_step[i]) begin
          r_y[i] <= r_y[i] + c_Y_ONE;
        end
        // Game over clears every slot, overriding anything above
        if (w_go_over || (r_state == c_ST_OVER)) begin
          r_active[i] <= 1'b0;
        end
      end
    end
  end

  // Reach pulse, lives counter and sticky game-over flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reached <= 1'b0;
      r_lives   <= '0;
      r_over    <= 1'b0;
    end else begin
      r_reached <= |w_reach;
      if (w_live) begin
        r_lives <= w_lives_next;
      end
      if (w_go_over) begin
        r_over <= 1'b1;
      end
    end
  end

  assign xenemy1       = r_x[0];
  assign yenemy1       = r_y[0];
  assign xenemy2       = r_x[1];
  assign yenemy2       = r_y[1];
  assign xenemy3       = r_x[2];
  assign yenemy3       = r_y[2];
  assign spawn_enemy1  = r_active[0];
  assign spawn_enemy2  = r_active[1];
  assign spawn_enemy3  = r_active[2];
  assign enemy_reached = r_reached;
  assign lives_lost    = r_lives;
  assign game_over     = r_over;

endmodule
`default_nettype wire

// File: tb/tb_enemy_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_spawner
//  Description : Self-checking bench for enemy_spawner: directed vector
//                table, hand-written kill / reach / pause sequences and a
//                randomized run compared against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_spawner;

  localparam int W  = 8;
  localparam int SI = 16;
  localparam int MD = 4;
  localparam int YL = 10;
  localparam int XM = 8;
  localparam int LV = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
  logic [W-1:0] x1, y1, x2, y2, x3, y3;
  logic         s1, s2, s3, reached, over;
  logic [3:0]   lives;

  enemy_spawner #(
    .OUT_WIDTH(W), .SPAWN_INTERVAL(SI), .MOVE_DIV(MD),
    .Y_LIMIT(YL), .X_MARGIN(XM), .LIVES(LV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .enemy1_kill(k1), .enemy2_kill(k2), .enemy3_kill(k3),
    .xenemy1(x1), .yenemy1(y1), .xenemy2(x2), .yenemy2(y2),
    .xenemy3(x3), .yenemy3(y3),
    .spawn_enemy1(s1), .spawn_enemy2(s2), .spawn_enemy3(s3),
    .enemy_reached(reached), .lives_lost(lives), .game_over(over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural game model ----------------
  // mode: 0 = just reset, 1 = running, 2 = paused, 3 = game over
  int          m_mode;
  int          m_run;        // RUN cycles elapsed since leaving reset
  logic [15:0] m_lfsr;
  bit          m_act [3];
  int          m_x [3];
  int          m_y [3];
  bit          m_reached;
  int          m_lives;
  bit          m_over;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int clamp_x(input int v);
    int hi;
    hi = (2 ** W) - 1 - XM;
    if (v < XM) return XM;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_lfsr = 16'hACE1;
    m_reached = 0; m_lives = 0; m_over = 0;
    for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
  endtask

  task automatic model_step(input bit en, input bit [2:0] kl);
    bit kok [3];
    int tgt;
    int nreach;
    bit tick;
    bit spawn;
    tgt = -1;
    nreach = 0;
    m_reached = 0;
    for (int i = 0; i < 3; i++) kok[i] = kl[i] && m_act[i];
    if (m_mode == 0) begin
      m_mode = 1;
      m_run  = 0;
    end else if (m_mode == 1) begin
      m_run++;
      tick  = (m_run % MD) == 0;
      spawn = (m_run % SI) == 0;
      if (spawn) begin
        for (int i = 2; i >= 0; i--) if (!m_act[i]) tgt = i;
      end
      for (int i = 0; i < 3; i++) begin
        if (m_act[i]) begin
          if (kok[i]) m_act[i] = 0;
          else if (tick) begin
            if (m_y[i] == YL) begin m_act[i] = 0; nreach++; end
            else m_y[i]++;
          end
        end
      end
      if (tgt >= 0) begin
        m_act[tgt] = 1;
        m_x[tgt]   = clamp_x(int'(m_lfsr[W-1:0]));
        m_y[tgt]   = 0;
      end
      m_lfsr    = lfsr_next(m_lfsr);
      m_lives   = (m_lives + nreach > LV) ? LV : m_lives + nreach;
      m_reached = (nreach > 0);
      if (m_lives == LV) begin
        m_mode = 3; m_over = 1;
        for (int i = 0; i < 3; i++) m_act[i] = 0;
      end else if (!en) begin
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      for (int i = 0; i < 3; i++) if (kok[i]) m_act[i] = 0;
      if (en) m_mode = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_spawn1", 32'(s1), 32'(m_act[0]));
    chk("m_spawn2", 32'(s2), 32'(m_act[1]));
    chk("m_spawn3", 32'(s3), 32'(m_act[2]));
    chk("m_x1", 32'(x1), m_x[0]);
    chk("m_y1", 32'(y1), m_y[0]);
    chk("m_x2", 32'(x2), m_x[1]);
    chk("m_y2", 32'(y2), m_y[1]);
    chk("m_x3", 32'(x3), m_x[2]);
    chk("m_y3", 32'(y3), m_y[2]);
    chk("m_reached", 32'(reached), 32'(m_reached));
    chk("m_lives", 32'(lives), m_lives);
    chk("m_over", 32'(over), 32'(m_over));
  endtask

  // One clock: drive inputs, advance the model, sample after the edge
  task automatic cycle(input bit r, input bit en, input bit [2:0] kl);
    rst = r; enable = en; {k3, k2, k1} = kl;
    if (r) model_reset();
    else   model_step(en, kl);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int       t;        // cycle index after reset release
    bit       en;
    bit [2:0] kill;
    bit [2:0] spawn;    // {s3,s2,s1}
    int       y1;
    bit       reached;
    int       lives;
    bit       over;
  } vec_t;

  vec_t tbl [15];
  int   t;
  bit   rr;
  bit   ren;
  bit [2:0] rkl;

  initial begin
    tbl[0]  = '{1,  1'b1, 3'b000, 3'b000, 0,  1'b0, 0, 1'b0};
    tbl[1]  = '{16, 1'b1, 3'b000, 3'b000, 0,  1'b0, 0, 1'b0};
    tbl[2]  = '{17, 1'b1, 3'b000, 3'b001, 0,  1'b0, 0, 1'b0};
    tbl[3]  = '{21, 1'b1, 3'b000, 3'b001, 1,  1'b0, 0, 1'b0};
    tbl[4]  = '{33, 1'b1, 3'b000, 3'b011, 4,  1'b0, 0, 1'b0};
    tbl[5]  = '{49, 1'b1, 3'b000, 3'b111, 8,  1'b0, 0, 1'b0};
    tbl[6]  = '{57, 1'b1, 3'b000, 3'b111, 10, 1'b0, 0, 1'b0};
    tbl[7]  = '{60, 1'b1, 3'b000, 3'b111, 10, 1'b0, 0, 1'b0};
    tbl[8]  = '{61, 1'b1, 3'b000, 3'b110, 10, 1'b1, 1, 1'b0};
    tbl[9]  = '{62, 1'b1, 3'b000, 3'b110, 10, 1'b0, 1, 1'b0};
    tbl[10] = '{65, 1'b1, 3'b000, 3'b111, 0,  1'b0, 1, 1'b0};
    tbl[11] = '{77, 1'b1, 3'b000, 3'b101, 3,  1'b1, 2, 1'b0};
    tbl[12] = '{93, 1'b1, 3'b000, 3'b000, 7,  1'b1, 3, 1'b1};
    tbl[13] = '{96, 1'b1, 3'b111, 3'b000, 7,  1'b0, 3, 1'b1};
    tbl[14] = '{98, 1'b1, 3'b000, 3'b000, 7,  1'b0, 3, 1'b1};

    // Reset state
    cycle(1'b1, 1'b1, 3'b000);
    cycle(1'b1, 1'b1, 3'b000);
    chk("rst_spawn", 32'({s3, s2, s1}), 32'd0);
    chk("rst_pos", 32'({x1, y1, x2, y2}), 32'd0);
    chk("rst_pos3", 32'({x3, y3}), 32'd0);
    chk("rst_status", 32'({reached, lives, over}), 32'd0);

    // Table: plain run to game over, then kills ignored in OVER
    t = 0;
    foreach (tbl[i]) begin
      while (t < tbl[i].t - 1) begin cycle(1'b0, 1'b1, 3'b000); t++; end
      cycle(1'b0, tbl[i].en, tbl[i].kill);
      t++;
      chk($sformatf("tbl%0d_spawn", i),   32'({s3, s2, s1}), 32'(tbl[i].spawn));
      chk($sformatf("tbl%0d_y1", i),      32'(y1), tbl[i].y1);
      chk($sformatf("tbl%0d_reached", i), 32'(reached), 32'(tbl[i].reached));
      chk($sformatf("tbl%0d_lives", i),   32'(lives), tbl[i].lives);
      chk($sformatf("tbl%0d_over", i),    32'(over), 32'(tbl[i].over));
      chk($sformatf("tbl%0d_x1range", i), 32'((x1 == 0) || (x1 >= XM && x1 <= 255 - XM)), 32'd1);
    end

    // Kill at y=3, respawn into lowest free slot
    cycle(1'b1, 1'b1, 3'b000);
    t = 0;
    while (t < 30) begin cycle(1'b0, 1'b1, 3'b000); t++; end
    chk("k_pre_y1", 32'(y1), 32'd3);
    cycle(1'b0, 1'b1, 3'b001); t++;
    chk("k_spawn1", 32'(s1), 32'd0);
    chk("k_hold_y1", 32'(y1), 32'd3);
    while (t < 33) begin cycle(1'b0, 1'b1, 3'b000); t++; end
    chk("k_respawn", 32'({s3, s2, s1}), 32'b001);
    chk("k_respawn_y1", 32'(y1), 32'd0);

    // Kill and reach on the same cycle: kill wins
    while (t < 76) begin cycle(1'b0, 1'b1, 3'b000); t++; end
    chk("kr_pre_y1", 32'(y1), 32'd10);
    cycle(1'b0, 1'b1, 3'b001); t++;
    chk("kr_reached", 32'(reached), 32'd0);
    chk("kr_lives", 32'(lives), 32'd0);
    chk("kr_spawn", 32'({s3, s2, s1}), 32'b110);

    // Pause for 20 cycles with a kill on slot 2 in the middle
    cycle(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, (i == 10) ? 3'b010 : 3'b000);
    chk("p_spawn", 32'({s3, s2, s1}), 32'b100);
    chk("p_y2", 32'(y2), 32'd7);
    chk("p_y3", 32'(y3), 32'd3);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 3'b000);

    // Randomized run against the model
    cycle(1'b1, 1'b1, 3'b000);
    for (int n = 0; n < 4000; n++) begin
      rr  = ($urandom_range(0, 299) == 0) || (m_over && ($urandom_range(0, 15) == 0));
      ren = ($urandom_range(0, 9) != 0);
      rkl = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 29) == 0)};
      cycle(rr, ren, rkl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
